// File: rtl/poly_tone_i2s.sv
// poly_tone_i2s: polyphonic square/saw tone synthesiser feeding an I2S DAC
// serialiser (BCLK / DACLRCLK / DACDAT). One mixer pass runs per audio frame
// and produces the {L,R} word that is shifted out during the following frame.
module poly_tone_i2s #(
    parameter int VOICES   = 4,
    parameter int PHASE_W  = 24,
    parameter int SAMPLE_W = 16,
    parameter int BCLK_DIV = 2
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      en,
    input  logic [VOICES-1:0]         voice_en,
    input  logic [VOICES-1:0]         voice_saw,
    input  logic [2*VOICES-1:0]       voice_pan,
    input  logic [VOICES*PHASE_W-1:0] freq,
    input  logic [3:0]                atten,
    output logic                      BCLK,
    output logic                      DACLRCLK,
    output logic                      DACDAT,
    output logic                      frame_tick,
    output logic                      clip
);
    localparam int FRAME_W = 2 * SAMPLE_W;
    localparam int CNT_W   = $clog2(FRAME_W);
    localparam int DIV_W   = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int VI_W    = (VOICES > 1) ? $clog2(VOICES) : 1;
    localparam int AW      = SAMPLE_W + $clog2(VOICES) + 1;

    localparam logic signed [AW-1:0]       SMAX  = AW'((2 ** (SAMPLE_W - 1)) - 1);
    localparam logic signed [AW-1:0]       SMIN  = AW'(-(2 ** (SAMPLE_W - 1)));
    localparam logic signed [SAMPLE_W-1:0] SQ_HI = SAMPLE_W'((2 ** (SAMPLE_W - 1)) - 1);
    localparam logic signed [SAMPLE_W-1:0] SQ_LO = SAMPLE_W'(-((2 ** (SAMPLE_W - 1)) - 1));

    // The whole mixer pass must finish inside one frame, otherwise pending
    // would be rewritten while the serialiser is about to load it.
    if (VOICES + 2 > 4 * BCLK_DIV * SAMPLE_W) begin : g_pass_fits
        $error("poly_tone_i2s: mixer pass longer than one frame");
    end
    if (VOICES < 1 || VOICES > 16 || PHASE_W < SAMPLE_W || BCLK_DIV < 1) begin : g_param_range
        $error("poly_tone_i2s: parameter out of range");
    end

    // ---------------------------------------------------------------- clocks
    logic [DIV_W-1:0]   div;
    logic [CNT_W-1:0]   bit_cnt;
    logic [CNT_W-1:0]   bit_nxt;
    logic [FRAME_W-1:0] shreg;
    logic [FRAME_W-1:0] pending;   // {L,R} produced by the last mixer pass
    logic               div_wrap;
    logic               fall_tgl;

    assign div_wrap = (div == DIV_W'(BCLK_DIV - 1));
    assign fall_tgl = div_wrap & BCLK;
    assign bit_nxt  = (bit_cnt == CNT_W'(FRAME_W - 1)) ? '0 : bit_cnt + CNT_W'(1);

    // BCLK divider: toggle BCLK every BCLK_DIV clk cycles
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div  <= '0;
            BCLK <= 1'b0;
        end else if (div_wrap) begin
            div  <= '0;
            BCLK <= ~BCLK;
        end else begin
            div <= div + DIV_W'(1);
        end
    end

    // Bit counter, LR clock and shift-out, all advanced on BCLK falling toggles.
    // The bit leaving at bit_cnt=0 is the previous frame's R LSB, so the new
    // word is loaded on that same toggle and its MSB leaves one BCLK later.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt    <= '0;
            DACLRCLK   <= 1'b0;
            DACDAT     <= 1'b0;
            shreg      <= '0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= fall_tgl && (bit_nxt == '0);
            if (fall_tgl) begin
                bit_cnt  <= bit_nxt;
                DACLRCLK <= (bit_nxt >= CNT_W'(SAMPLE_W));
                DACDAT   <= shreg[FRAME_W-1];
                shreg    <= (bit_nxt == '0) ? pending : {shreg[FRAME_W-2:0], 1'b0};
            end
        end
    end

    // ----------------------------------------------------------------- mixer
    typedef enum logic [1:0] {IDLE, ACC, SCALE} mix_state_t;
    mix_state_t state, state_nxt;

    logic [VI_W-1:0]                vi;
    logic                           last_voice;
    logic                           mix_start, acc_on, scale_on;
    logic [VOICES-1:0][PHASE_W-1:0] phase;
    logic [VOICES-1:0][PHASE_W-1:0] freq_a;
    logic [VOICES-1:0][1:0]         pan_a;
    logic signed [AW-1:0]           acc_l, acc_r;

    assign freq_a     = freq;
    assign pan_a      = voice_pan;
    assign last_voice = (vi == VI_W'(VOICES - 1));

    // Mixer state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Mixer next state: one pass per frame start
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (frame_tick) state_nxt = ACC;
            ACC:     if (last_voice) state_nxt = SCALE;
            SCALE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Mixer control outputs
    always_comb begin
        mix_start = (state == IDLE) && frame_tick;
        acc_on    = (state == ACC);
        scale_on  = (state == SCALE);
    end

    // Current voice's waveform value from its pre-increment phase
    logic [PHASE_W-1:0]         p_cur;
    logic signed [SAMPLE_W-1:0] v_val;
    logic signed [AW-1:0]       v_ext;
    logic                       v_on;

    // Waveform lookup for the voice selected by vi
    always_comb begin
        p_cur = phase[vi];
        v_on  = voice_en[vi] & en;
        if (voice_saw[vi]) v_val = p_cur[PHASE_W-1 -: SAMPLE_W];
        else               v_val = p_cur[PHASE_W-1] ? SQ_LO : SQ_HI;
        v_ext = {{(AW - SAMPLE_W){v_val[SAMPLE_W-1]}}, v_val};
    end

    // Accumulate one voice per cycle; idle voices are parked at phase 0
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vi    <= '0;
            acc_l <= '0;
            acc_r <= '0;
            phase <= '0;
        end else if (mix_start) begin
            vi    <= '0;
            acc_l <= '0;
            acc_r <= '0;
        end else if (acc_on) begin
            if (v_on) begin
                if (pan_a[vi][0]) acc_l <= acc_l + v_ext;
                if (pan_a[vi][1]) acc_r <= acc_r + v_ext;
                phase[vi] <= p_cur + freq_a[vi];
            end else begin
                phase[vi] <= '0;
            end
            vi <= last_voice ? '0 : vi + VI_W'(1);
        end
    end

    // Attenuate then saturate; MSB of the result flags saturation
    function automatic logic [SAMPLE_W:0] sat_shift(input logic signed [AW-1:0] a,
                                                    input logic [3:0] sh);
        logic signed [AW-1:0] s;
        s = a >>> sh;
        if (s > SMAX)      return {1'b1, SMAX[SAMPLE_W-1:0]};
        else if (s < SMIN) return {1'b1, SMIN[SAMPLE_W-1:0]};
        else               return {1'b0, s[SAMPLE_W-1:0]};
    endfunction

    logic [SAMPLE_W:0] sat_l, sat_r;
    assign sat_l = sat_shift(acc_l, atten);
    assign sat_r = sat_shift(acc_r, atten);

    // SCALE: publish the pending word and pulse clip on saturation
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending <= '0;
            clip    <= 1'b0;
        end else begin
            clip <= 1'b0;
            if (scale_on) begin
                if (en) begin
                    pending <= {sat_l[SAMPLE_W-1:0], sat_r[SAMPLE_W-1:0]};
                    clip    <= sat_l[SAMPLE_W] | sat_r[SAMPLE_W];
                end else begin
                    pending <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_poly_tone_i2s.sv
// Bench for poly_tone_i2s: reconstructs each I2S frame from DACDAT on BCLK
// rising and compares it with a frame-level arithmetic model of the synth.
module tb_poly_tone_i2s;
    localparam int V  = 4;
    localparam int PW = 24;
    localparam int SW = 16;
    localparam int BD = 2;
    localparam int MAXV = 2 ** (SW - 1) - 1;
    localparam int MINV = -(2 ** (SW - 1));

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              en = 1'b0;
    logic [V-1:0]      voice_en = '0;
    logic [V-1:0]      voice_saw = '0;
    logic [2*V-1:0]    voice_pan = '0;
    logic [V*PW-1:0]   freq = '0;
    logic [3:0]        atten = '0;
    logic              BCLK, DACLRCLK, DACDAT, frame_tick, clip;

    int checks = 0, passed = 0, fails = 0;
    int clip_cnt = 0;
    bit bclk_now = 1'b0, bclk_prev = 1'b0;

    // frame-level model state
    logic [PW-1:0] ph[V];
    logic [31:0]   exp_q[$];
    logic [31:0]   rx;
    bit            have_rx = 1'b0;
    bit            clip_known = 1'b0;
    int            clip_exp = 0;
    int            clip_mark = 0;

    poly_tone_i2s #(.VOICES(V), .PHASE_W(PW), .SAMPLE_W(SW), .BCLK_DIV(BD)) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .voice_en(voice_en),
        .voice_saw(voice_saw), .voice_pan(voice_pan), .freq(freq), .atten(atten),
        .BCLK(BCLK), .DACLRCLK(DACLRCLK), .DACDAT(DACDAT),
        .frame_tick(frame_tick), .clip(clip)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (reset_n && clip) clip_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tmo(input string tag);
        checks++;
        fails++;
        $display("FAIL timeout %s: observed no event, expected one within budget", tag);
    endtask

    task automatic step();
        @(negedge clk);
        bclk_prev = bclk_now;
        bclk_now  = BCLK;
    endtask

    task automatic bclk_rise(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 4 * BD + 2; i++) begin
            step();
            if (bclk_now && !bclk_prev) begin ok = 1'b1; break; end
        end
        if (!ok) tmo("bclk_rise");
    endtask

    task automatic wait_tick(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 4 * BD * SW + 8; i++) begin
            step();
            if (frame_tick) begin ok = 1'b1; break; end
        end
        if (!ok) tmo("frame_tick");
    endtask

    // One mixer pass computed from the rules with plain integers
    task automatic model_pass();
        int acc_l, acc_r, val, sl, sr;
        bit c;
        acc_l = 0; acc_r = 0;
        for (int v = 0; v < V; v++) begin
            if (en && voice_en[v]) begin
                if (voice_saw[v]) val = $signed(ph[v][PW-1 -: SW]);
                else              val = ph[v][PW-1] ? -MAXV : MAXV;
                if (voice_pan[2*v])   acc_l += val;
                if (voice_pan[2*v+1]) acc_r += val;
                ph[v] = ph[v] + freq[v*PW +: PW];
            end else begin
                ph[v] = '0;
            end
        end
        sl = acc_l >>> atten;
        sr = acc_r >>> atten;
        c  = (sl > MAXV) || (sl < MINV) || (sr > MAXV) || (sr < MINV);
        sl = (sl > MAXV) ? MAXV : (sl < MINV) ? MINV : sl;
        sr = (sr > MAXV) ? MAXV : (sr < MINV) ? MINV : sr;
        if (!en) begin sl = 0; sr = 0; c = 1'b0; end
        exp_q.push_back({sl[15:0], sr[15:0]});
        clip_exp   = int'(c);
        clip_known = 1'b1;
    endtask

    task automatic model_clear();
        for (int v = 0; v < V; v++) ph[v] = '0;
        exp_q.delete();
        have_rx    = 1'b0;
        clip_known = 1'b0;
    endtask

    // Follow n frames; returns just after the last bit_cnt=31 rising edge
    task automatic run(input int n);
        bit ok;
        logic [31:0] exp;
        for (int f = 0; f < n; f++) begin
            wait_tick(ok);
            if (!ok) return;
            if (clip_known) chk("clip_pulses", clip_cnt - clip_mark, clip_exp);
            clip_mark = clip_cnt;
            bclk_rise(ok);
            if (!ok) return;
            chk("lrclk_bit0", DACLRCLK, 0);
            if (have_rx) begin
                exp = exp_q.pop_front();
                chk("frame_word", {rx[30:0], DACDAT}, exp);
            end
            have_rx = (exp_q.size() > 0);
            model_pass();
            for (int k = 1; k < 2 * SW; k++) begin
                bclk_rise(ok);
                if (!ok) return;
                chk("lrclk", DACLRCLK, (k >= SW) ? 1 : 0);
                rx = {rx[30:0], DACDAT};
            end
        end
    endtask

    initial begin
        bit ok;
        int br[$], lr[$], ft[$];
        bit lr_prev;
        model_clear();

        // reset state
        repeat (3) step();
        chk("rst_bclk", BCLK, 0);
        chk("rst_lrclk", DACLRCLK, 0);
        chk("rst_dacdat", DACDAT, 0);
        chk("rst_tick", frame_tick, 0);
        chk("rst_clip", clip, 0);

        // timing after release
        reset_n = 1'b1;
        bclk_now = 1'b0;
        lr_prev = 1'b0;
        for (int cyc = 1; cyc <= 300; cyc++) begin
            step();
            if (bclk_now && !bclk_prev) br.push_back(cyc);
            if (DACLRCLK && !lr_prev) lr.push_back(cyc);
            lr_prev = DACLRCLK;
            if (frame_tick) ft.push_back(cyc);
        end
        chk("bclk_first", (br.size() > 0) ? br[0] : -1, 2);
        chk("bclk_period", (br.size() > 1) ? br[1] - br[0] : -1, 4);
        chk("lrclk_first", (lr.size() > 0) ? lr[0] : -1, 64);
        chk("lrclk_period", (lr.size() > 1) ? lr[1] - lr[0] : -1, 128);
        chk("tick_first", (ft.size() > 0) ? ft[0] : -1, 128);
        chk("tick_period", (ft.size() > 1) ? ft[1] - ft[0] : -1, 128);

        // saw on voice 0, both channels: 0x0000, 0x1000, ... wrapping
        en = 1'b1; atten = 4'd0;
        voice_en = 4'b0001; voice_saw = 4'b0001; voice_pan = 8'b0000_0011;
        freq = '0; freq[0 +: PW] = 24'h100000;
        run(18);

        // square on voice 0, left only
        voice_saw = 4'b0000; voice_pan = 8'b0000_0001;
        freq[0 +: PW] = 24'h800000;
        run(6);

        // saturation: two full-scale squares summed
        voice_en = 4'b0011; voice_pan = 8'b0000_1111; freq = '0;
        run(4);
        atten = 4'd1;
        run(3);

        // framing pattern L=0xA5A5, R=0x5A5A built from parked saw phases
        atten = 4'd0; voice_en = 4'b0000;
        run(1);
        voice_en = 4'b0011; voice_saw = 4'b0011; voice_pan = 8'b0000_1001;
        freq[0 +: PW] = 24'hA5A500; freq[PW +: PW] = 24'h5A5A00;
        run(1);
        freq = '0;
        run(3);

        // disable / re-enable restarts the saw at phase 0
        voice_en = 4'b0001; voice_saw = 4'b0001; voice_pan = 8'b0000_0011;
        freq[0 +: PW] = 24'h100000;
        run(3);
        voice_en = 4'b0000;
        run(1);
        voice_en = 4'b0001;
        run(3);
        en = 1'b0;
        run(2);

        // randomized voices
        for (int r = 0; r < 12; r++) begin
            en        = ($urandom_range(0, 7) != 0);
            voice_en  = V'($urandom);
            voice_saw = V'($urandom);
            voice_pan = (2*V)'($urandom);
            for (int v = 0; v < V; v++) freq[v*PW +: PW] = PW'($urandom);
            atten     = 4'($urandom_range(0, 3));
            run(1);
        end

        // reset in the middle of a frame at bit_cnt=20
        wait_tick(ok);
        for (int k = 0; k <= 20; k++) bclk_rise(ok);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_bclk", BCLK, 0);
        chk("midrst_lrclk", DACLRCLK, 0);
        chk("midrst_dacdat", DACDAT, 0);
        chk("midrst_tick", frame_tick, 0);
        chk("midrst_clip", clip, 0);
        repeat (3) step();
        reset_n = 1'b1;
        model_clear();
        repeat (8) step();

        for (int r = 0; r < 6; r++) begin
            en        = 1'b1;
            voice_en  = V'($urandom);
            voice_saw = V'($urandom);
            voice_pan = (2*V)'($urandom);
            for (int v = 0; v < V; v++) freq[v*PW +: PW] = PW'($urandom);
            atten     = 4'($urandom_range(0, 2));
            run(1);
        end
        run(2);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
